cam_axis_bridge: RTL and testbench
==================================

Name: cam_axis_bridge

Overview:
- Synthesizable camera-parallel-to-AXI4-Stream video bridge.
- Converts frame-valid/line-valid/pixel-data input into an AXI4-Stream video master with tuser (start of frame) and tlast (end of line).
- Adds a parametrised data width, frame geometry and skid FIFO for tready backpressure.
- Adds frame-geometry error detection and overflow handling; single clock domain (pclk drives both the video and stream sides).

Parameters:
DATA_W, 16, pixel/tdata width in bits
WIDTH, 640, expected active pixels per line
HEIGHT, 480, expected active lines per frame
FIFO_DEPTH, 16, output FIFO entries; power of two, >=4

Ports:
pclk  input  1  clock; one domain, everything samples on the rising edge
reset  input  1  synchronous, active-high reset
fv  input  1  frame valid
lv  input  1  line valid; ignored while fv=0
d_in  input  DATA_W  pixel data, valid when fv&lv
m_axis_tdata  output  DATA_W  stream pixel
m_axis_tvalid  output  1  FIFO not empty
m_axis_tready  input  1  downstream ready
m_axis_tuser  output  1  first pixel of frame
m_axis_tlast  output  1  last pixel of line
frame_done  output  1  one-cycle pulse at fv falling edge of a captured frame
line_len_err  output  1  one-cycle pulse: a line ended with pixel count != WIDTH
frame_len_err  output  1  one-cycle pulse with frame_done: line count != HEIGHT
overflow  output  1  sticky; set when a pixel is lost to a full FIFO; cleared only by reset

Behaviour:
- Inputs fv, lv, d_in are registered once (stage 0). All edge detection uses the registered value versus its previous value.
- Reset: every output 0. FIFO is emptied, counters are 0, and the FSM goes to ARM.
- FSM states:
  - ARM: wait for fv=0, then go to WAIT_SOF. This prevents capturing a partial frame after reset.
  - WAIT_SOF: on fv rising edge, go to ACTIVE and set sof_pending=1.
  - ACTIVE: capture pixels. On fv falling edge, go to WAIT_SOF.
  - DROP: discard all pixels until fv falls, then go to WAIT_SOF.
- Staging register: each accepted pixel is held in a one-entry stage.
  - The stage is written into the FIFO when the next pixel arrives (tlast=0), or on the lv falling edge (tlast=1).
  - tlast therefore marks the actual last pixel of every line.
  - Pixel-to-FIFO latency is at most 2 cycles after stage 0.
- tuser is 1 on the first pixel staged while sof_pending=1, then sof_pending clears. Exactly one tuser per frame.
- Counters:
  - col counts pixels per line and saturates at 2^16-1.
  - row counts lv falling edges inside ACTIVE.
  - On lv falling edge, if col != WIDTH, pulse line_len_err; col then resets to 0.
  - Pixels beyond WIDTH are still forwarded.
- Frame end: on fv falling edge in ACTIVE, pulse frame_done. Pulse frame_len_err in the same cycle if row != HEIGHT.
  - If fv falls while lv is still 1, treat it as an lv fall in the same cycle: flush the stage with tlast=1, then run the line check, then the frame check.
- FIFO:
  - Entry is {tuser, tlast, tdata}; outputs come directly from the head entry.
  - A beat is popped when tvalid&tready.
  - m_axis_tdata, m_axis_tuser and m_axis_tlast are stable while tvalid=1 and tready=0.
- Full FIFO:
  - A write into a full FIFO succeeds only if a pop occurs in the same cycle.
  - Otherwise the pixel is lost, overflow is set, and the FSM goes to DROP.
  - Beats already in the FIFO continue to drain. No further writes occur until the next WAIT_SOF→ACTIVE transition.
  - frame_done is not pulsed for a dropped frame.
- Empty FIFO with a simultaneous write: the data appears on tvalid the next cycle. There is no fall-through.
- lv=1 while fv=0 is ignored and not counted.
- reset asserted mid-frame: behaves as described under Reset. The next capture starts only after fv low→high.

Test Plan:
- WIDTH=8, HEIGHT=4, FIFO_DEPTH=16, tready=1, front porch then 4 lines of 8 pixels (d_in=col+16*row) → 32 beats total; tuser only on data 0x00; tlast on 0x07, 0x17, 0x27, 0x37; frame_done=1 once; no error pulses.
- Same frame with tready toggled 1/0 every cycle → identical beat sequence; data held stable during stalls; overflow=0.
- Line 2 has 6 pixels and the frame has 5 lines → line_len_err pulses once at that line's lv fall; tlast on its 6th pixel; frame_len_err=1 coincident with frame_done.
- FIFO_DEPTH=4, tready=0 for the whole frame → overflow=1 at the 6th pixel (4 in FIFO, 1 in stage); FSM in DROP; 4 beats drain after tready=1; no frame_done; the next frame is captured cleanly with tuser=1 on its first beat.
- Reset released while fv=1 mid-line → no beats until fv falls and rises again; the following full frame produces 32 beats with correct tuser/tlast.
- fv and lv fall in the same cycle on the last line → the last pixel has tlast=1; row=4; frame_done=1; frame_len_err=0.

Source files
------------

// File: rtl/cam_axis_bridge.sv
// Camera parallel (fv/lv/data) to AXI4-Stream video bridge.
// One-entry staging register lets tlast mark the real last pixel of each line;
// a power-of-two FIFO absorbs tready backpressure.
`timescale 1ns/1ps
module cam_axis_bridge #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              fv,
    input  logic              lv,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              frame_done,
    output logic              line_len_err,
    output logic              frame_len_err,
    output logic              overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_W + 2;
    localparam logic [15:0] WidthC  = 16'(WIDTH);
    localparam logic [15:0] HeightC = 16'(HEIGHT);
    localparam logic [AW:0] PtrOne  = (AW+1)'(1);

    typedef enum logic [1:0] {StArm, StWaitSof, StActive, StDrop} state_e;

    state_e state_q, state_d;

    // Stage 0 input registers and their previous values for edge detection
    logic              fv_q, fv_p_q, lv_q, lv_p_q;
    logic [DATA_W-1:0] d_q;
    logic              lv_eff, pix, fv_rise, fv_fall, lv_fall;

    logic              sof_q, sof_d;
    logic              stage_valid_q, stage_valid_d;
    logic              stage_user_q, stage_user_d;
    logic [DATA_W-1:0] stage_data_q, stage_data_d;
    logic [15:0]       col_q, col_d, row_q, row_d;
    logic              done_q, done_d, lerr_q, lerr_d, ferr_q, ferr_d, ovf_q, ovf_d;

    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic              full, empty, pop, wr_req, wr_en;
    logic [EW-1:0]     wr_entry, head;

    // lv only counts while fv is high, so an fv fall also acts as an lv fall
    assign lv_eff  = fv_q & lv_q;
    assign pix     = lv_eff;
    assign fv_rise = fv_q & ~fv_p_q;
    assign fv_fall = ~fv_q & fv_p_q;
    assign lv_fall = lv_p_q & ~lv_eff;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = ~empty & m_axis_tready;
    assign wr_en = wr_req & (~full | pop);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // fv resets high so ARM cannot mistake the post-reset sample for a real fv rise
    always_ff @(posedge pclk) begin
        if (reset) begin
            fv_q   <= 1'b1;
            fv_p_q <= 1'b1;
            lv_q   <= 1'b0;
            lv_p_q <= 1'b0;
            d_q    <= '0;
        end else begin
            fv_q   <= fv;
            fv_p_q <= fv_q;
            lv_q   <= lv;
            lv_p_q <= lv_eff;
            d_q    <= d_in;
        end
    end

    // Capture FSM, staging, counters and error detection
    always_comb begin
        state_d       = state_q;
        sof_d         = sof_q;
        stage_valid_d = stage_valid_q;
        stage_user_d  = stage_user_q;
        stage_data_d  = stage_data_q;
        col_d         = col_q;
        row_d         = row_q;
        done_d        = 1'b0;
        lerr_d        = 1'b0;
        ferr_d        = 1'b0;
        ovf_d         = ovf_q;
        wr_req        = 1'b0;
        wr_entry      = {stage_user_q, 1'b0, stage_data_q};
        unique case (state_q)
            StArm: begin
                if (!fv_q) state_d = StWaitSof;
            end
            StWaitSof: begin
                if (fv_rise) begin
                    state_d       = StActive;
                    sof_d         = 1'b1;
                    col_d         = '0;
                    row_d         = '0;
                    stage_valid_d = 1'b0;
                end
            end
            StActive: begin
                if (pix) begin
                    wr_req        = stage_valid_q;
                    stage_valid_d = 1'b1;
                    stage_data_d  = d_q;
                    stage_user_d  = sof_q;
                    sof_d         = 1'b0;
                    if (col_q != 16'hFFFF) col_d = col_q + 16'd1;
                end
                if (lv_fall) begin
                    wr_req        = stage_valid_q;
                    wr_entry      = {stage_user_q, 1'b1, stage_data_q};
                    stage_valid_d = 1'b0;
                    lerr_d        = (col_q != WidthC);
                    col_d         = '0;
                    if (row_q != 16'hFFFF) row_d = row_q + 16'd1;
                end
                if (fv_fall) begin
                    done_d  = 1'b1;
                    ferr_d  = (row_d != HeightC);
                    state_d = StWaitSof;
                end
                // Lost pixel: abandon the rest of this frame
                if (wr_req && full && !pop) begin
                    ovf_d         = 1'b1;
                    state_d       = StDrop;
                    stage_valid_d = 1'b0;
                    done_d        = 1'b0;
                    ferr_d        = 1'b0;
                end
            end
            StDrop: begin
                if (!fv_q) state_d = StWaitSof;
            end
            default: state_d = StArm;
        endcase
    end

    // Control state registers
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q       <= StArm;
            sof_q         <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_user_q  <= 1'b0;
            stage_data_q  <= '0;
            col_q         <= '0;
            row_q         <= '0;
            done_q        <= 1'b0;
            lerr_q        <= 1'b0;
            ferr_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sof_q         <= sof_d;
            stage_valid_q <= stage_valid_d;
            stage_user_q  <= stage_user_d;
            stage_data_q  <= stage_data_d;
            col_q         <= col_d;
            row_q         <= row_d;
            done_q        <= done_d;
            lerr_q        <= lerr_d;
            ferr_q        <= ferr_d;
            ovf_q         <= ovf_d;
        end
    end

    // FIFO pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge pclk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)   rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge pclk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    assign m_axis_tvalid = ~empty;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = empty ? '0 : head;
    assign frame_done    = done_q;
    assign line_len_err  = lerr_q;
    assign frame_len_err = ferr_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_cam_axis_bridge.sv
// Bench for cam_axis_bridge: a 16-deep instance checked beat-by-beat against a
// scoreboard, and a 4-deep instance used for the overflow scenario.
`timescale 1ns/1ps
module tb_cam_axis_bridge;

    localparam int DW  = 16;
    localparam int WID = 8;
    localparam int HGT = 4;

    typedef logic [DW+1:0] beat_t;

    logic          pclk = 1'b0;
    logic          reset, fv, lv, tready, tready4;
    logic [DW-1:0] d_in;
    logic [DW-1:0] tdata, tdata4;
    logic          tvalid, tuser, tlast, fdone, lerr, ferr, ovf;
    logic          tvalid4, tuser4, tlast4, fdone4, lerr4, ferr4, ovf4;

    cam_axis_bridge #(.DATA_W(DW), .WIDTH(WID), .HEIGHT(HGT), .FIFO_DEPTH(16)) u_dut (
        .pclk(pclk), .reset(reset), .fv(fv), .lv(lv), .d_in(d_in),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast), .frame_done(fdone),
        .line_len_err(lerr), .frame_len_err(ferr), .overflow(ovf)
    );

    cam_axis_bridge #(.DATA_W(DW), .WIDTH(WID), .HEIGHT(HGT), .FIFO_DEPTH(4)) u_dut4 (
        .pclk(pclk), .reset(reset), .fv(fv), .lv(lv), .d_in(d_in),
        .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4), .m_axis_tready(tready4),
        .m_axis_tuser(tuser4), .m_axis_tlast(tlast4), .frame_done(fdone4),
        .line_len_err(lerr4), .frame_len_err(ferr4), .overflow(ovf4)
    );

    initial forever #5 pclk = ~pclk;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];
    beat_t obs4_q[$];
    int    fd_cnt = 0, lerr_cnt = 0, ferr_cnt = 0, beats = 0, fd4_cnt = 0;
    bit    toggle = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Sampled on the falling edge, between input updates
    task automatic monitor();
        if (reset) return;
        if (fdone) fd_cnt++;
        if (lerr) lerr_cnt++;
        if (ferr) begin
            ferr_cnt++;
            check_eq("ferr_with_done", 32'(fdone), 32'd1);
        end
        if (tvalid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_beat", 32'(tvalid), 32'd0);
            end else if (tready) begin
                check_eq("beat", 32'({tuser, tlast, tdata}), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                beats++;
            end else begin
                check_eq("stall_hold", 32'({tuser, tlast, tdata}), 32'(exp_q[0]));
            end
        end
        if (tvalid4 && tready4) obs4_q.push_back({tuser4, tlast4, tdata4});
        if (fdone4) fd4_cnt++;
    endtask

    task automatic tick();
        @(negedge pclk);
        monitor();
        @(posedge pclk);
        #1;
        if (toggle) tready = ~tready;
    endtask

    task automatic drive_frame(input int nl, input int lens[8], input bit same_fall,
                               input bit push);
        fv = 1'b1;
        lv = 1'b0;
        repeat (3) tick();
        for (int r = 0; r < nl; r++) begin
            for (int c = 0; c < lens[r]; c++) begin
                lv   = 1'b1;
                d_in = DW'(c + 16 * r);
                if (push) exp_q.push_back({(r == 0 && c == 0), (c == lens[r] - 1), d_in});
                tick();
            end
            if (same_fall && r == nl - 1) begin
                fv = 1'b0;
                lv = 1'b0;
            end else begin
                lv = 1'b0;
                repeat (4) tick();
            end
        end
        if (!same_fall) begin
            repeat (2) tick();
            fv = 1'b0;
        end
        repeat (6) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    int full_lens[8] = '{8, 8, 8, 8, 0, 0, 0, 0};
    int bad_lens[8]  = '{8, 8, 6, 8, 8, 0, 0, 0};
    int b_fd, b_le, b_fe, b_bt, b_fd4, b_ob;

    task automatic snap();
        b_fd  = fd_cnt;
        b_le  = lerr_cnt;
        b_fe  = ferr_cnt;
        b_bt  = beats;
        b_fd4 = fd4_cnt;
        b_ob  = obs4_q.size();
    endtask

    task automatic frame_counts(input string tag, input int nbeats, input int nle, input int nfe);
        check_eq({tag, "_beats"}, 32'(beats - b_bt), 32'(nbeats));
        check_eq({tag, "_done"}, 32'(fd_cnt - b_fd), 32'd1);
        check_eq({tag, "_lerr"}, 32'(lerr_cnt - b_le), 32'(nle));
        check_eq({tag, "_ferr"}, 32'(ferr_cnt - b_fe), 32'(nfe));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        fv      = 1'b0;
        lv      = 1'b0;
        d_in    = '0;
        tready  = 1'b1;
        tready4 = 1'b1;
        repeat (3) tick();
        check_eq("rst_tvalid", 32'(tvalid), 32'd0);
        check_eq("rst_tdata", 32'(tdata), 32'd0);
        check_eq("rst_tuser", 32'(tuser), 32'd0);
        check_eq("rst_tlast", 32'(tlast), 32'd0);
        check_eq("rst_pulses", 32'({fdone, lerr, ferr}), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_tvalid4", 32'(tvalid4), 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Nominal frame, always ready
        snap();
        drive_frame(4, full_lens, 1'b0, 1'b1);
        drain();
        frame_counts("nominal", 32, 0, 0);

        // Same frame with tready toggling every cycle
        snap();
        toggle = 1'b1;
        drive_frame(4, full_lens, 1'b0, 1'b1);
        drain();
        toggle = 1'b0;
        tready = 1'b1;
        frame_counts("toggle", 32, 0, 0);

        // Short third line and one extra line
        snap();
        drive_frame(5, bad_lens, 1'b0, 1'b1);
        drain();
        frame_counts("geom", 38, 1, 1);

        // Overflow on the 4-deep instance
        check_eq("ovf4_before", 32'(ovf4), 32'd0);
        snap();
        tready4 = 1'b0;
        drive_frame(4, full_lens, 1'b0, 1'b1);
        drain();
        check_eq("ovf4_set", 32'(ovf4), 32'd1);
        check_eq("ovf4_no_done", 32'(fd4_cnt - b_fd4), 32'd0);
        tready4 = 1'b1;
        repeat (10) tick();
        check_eq("ovf4_drain_cnt", 32'(obs4_q.size() - b_ob), 32'd4);
        for (int i = 0; i < 4 && b_ob + i < obs4_q.size(); i++)
            check_eq("ovf4_drain_beat", 32'(obs4_q[b_ob + i]), 32'({(i == 0), 1'b0, DW'(i)}));
        snap();
        drive_frame(4, full_lens, 1'b0, 1'b1);
        drain();
        repeat (5) tick();
        check_eq("ovf4_next_cnt", 32'(obs4_q.size() - b_ob), 32'd32);
        if (obs4_q.size() > b_ob)
            check_eq("ovf4_next_first", 32'(obs4_q[b_ob]), 32'({1'b1, 1'b0, DW'(0)}));
        if (obs4_q.size() >= b_ob + 32)
            check_eq("ovf4_next_last", 32'(obs4_q[b_ob + 31]), 32'({1'b0, 1'b1, DW'('h37)}));
        check_eq("ovf4_next_done", 32'(fd4_cnt - b_fd4), 32'd1);
        check_eq("ovf4_sticky", 32'(ovf4), 32'd1);

        // Reset released while fv=1 mid-line: that frame must be ignored
        reset = 1'b1;
        tick();
        fv = 1'b1;
        lv = 1'b0;
        repeat (2) tick();
        lv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            d_in = DW'(c);
            tick();
        end
        reset = 1'b0;
        snap();
        for (int c = 3; c < 8; c++) begin
            d_in = DW'(c);
            tick();
        end
        lv = 1'b0;
        repeat (4) tick();
        lv = 1'b1;
        repeat (8) tick();
        lv = 1'b0;
        repeat (3) tick();
        fv = 1'b0;
        repeat (6) tick();
        check_eq("rstmid_no_beats", 32'(beats - b_bt), 32'd0);
        check_eq("rstmid_no_done", 32'(fd_cnt - b_fd), 32'd0);
        check_eq("rstmid_ovf4_clr", 32'(ovf4), 32'd0);
        snap();
        drive_frame(4, full_lens, 1'b0, 1'b1);
        drain();
        frame_counts("rstmid_next", 32, 0, 0);

        // fv and lv fall together on the last line
        snap();
        drive_frame(4, full_lens, 1'b1, 1'b1);
        drain();
        frame_counts("samefall", 32, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
